offnariscv_wb_stage: RTL

- Write-back/commit stage, directly downstream of EX.
- Joins the in-order EX sideband stream (exwb_tdata_t) with the result stream of the functional unit that executed the instruction (aluwb/bruwb/syswb) and retires one instruction per cycle.
- Emits a registered register-file write (wbrf_tdata_t), a registered CSR write, branch redirect/flush, system-event pulses and a 64-bit retired-instruction counter.

---
 rtl/offnariscv_wb_stage.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/offnariscv_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | offnariscv_wb_stage: write-back/commit stage joining the EX sideband with   |
// | ALU/BRU/SYS results. Revision 1.0                                           |
// +----------------------------------------------------------------------------+

package offnariscv_wb_pkg;
  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    SYS_CSR        = 3'd0,
    SYS_ECALL      = 3'd1,
    SYS_EBREAK     = 3'd2,
    SYS_MRET       = 3'd3,
    SYS_SRET       = 3'd4,
    SYS_WFI        = 3'd5,
    SYS_SFENCE_VMA = 3'd6
  } system_cmd_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] immediate;
    logic [4:0]      rd;
    logic [11:0]     csr_addr;
    logic            alu_cmd_vld;
    logic            bru_cmd_vld;
    logic            sys_cmd_vld;
    system_cmd_e     sys_cmd;
  } id_data_t;

  typedef struct packed {
    id_data_t id_data;
    logic     int_exc_valid;
  } exwb_tdata_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
  } aluwb_tdata_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] new_pc;
    logic            taken;
  } bruwb_tdata_t;

  typedef struct packed {
    logic            csr_update;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_wmask;
  } syswb_tdata_t;

  typedef struct packed {
    logic [XLEN-1:0] wdata;
    exwb_tdata_t     ex_data;
  } wbrf_tdata_t;
endpackage

module offnariscv_wb_stage
  import offnariscv_wb_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC      = 32'h0000_0000,
  parameter int              INSTRET_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_exwb_tvalid,
  output logic                     s_exwb_tready,
  input  exwb_tdata_t              s_exwb_tdata,
  input  logic                     s_aluwb_tvalid,
  output logic                     s_aluwb_tready,
  input  aluwb_tdata_t             s_aluwb_tdata,
  input  logic                     s_bruwb_tvalid,
  output logic                     s_bruwb_tready,
  input  bruwb_tdata_t             s_bruwb_tdata,
  input  logic                     s_syswb_tvalid,
  output logic                     s_syswb_tready,
  input  syswb_tdata_t             s_syswb_tdata,
  output logic [11:0]              csr_raddr,
  input  logic [XLEN-1:0]          csr_rdata,
  output logic                     m_wbrf_tvalid,
  output wbrf_tdata_t              m_wbrf_tdata,
  output logic                     csr_we,
  output logic [11:0]              csr_waddr,
  output logic [XLEN-1:0]          csr_wdata,
  output logic [XLEN-1:0]          csr_wmask,
  output logic                     flush,
  output logic [XLEN-1:0]          redirect_pc,
  output logic                     sys_event_vld,
  output system_cmd_e              sys_event_cmd,
  output logic                     sys_event_exc,
  output logic [INSTRET_WIDTH-1:0] instret
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    UNIT_NONE = 2'd0,
    UNIT_ALU  = 2'd1,
    UNIT_BRU  = 2'd2,
    UNIT_SYS  = 2'd3
  } unit_e;

  state_e          state_q, state_d;
  unit_e           unit;
  id_data_t        head;
  logic            exc;
  logic            unit_vld;
  logic            fire;
  logic            sys_evt;
  logic            bru_taken;
  logic            raise_flush;
  logic            rf_wr;
  logic            csr_wr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] next_pc;

  assign csr_raddr = s_exwb_tdata.id_data.csr_addr;

  always_comb begin
    head     = s_exwb_tdata.id_data;
    exc      = s_exwb_tdata.int_exc_valid;
    unit     = UNIT_NONE;
    unit_vld = 1'b1;
    if (head.bru_cmd_vld) begin
      unit     = UNIT_BRU;
      unit_vld = s_bruwb_tvalid;
    end else if (head.sys_cmd_vld) begin
      unit     = UNIT_SYS;
      unit_vld = s_syswb_tvalid;
    end else if (head.alu_cmd_vld) begin
      unit     = UNIT_ALU;
      unit_vld = s_aluwb_tvalid;
    end

    fire           = (state_q == ST_RUN) && s_exwb_tvalid && unit_vld;
    s_exwb_tready  = fire;
    s_aluwb_tready = fire && (unit == UNIT_ALU);
    s_bruwb_tready = fire && (unit == UNIT_BRU);
    s_syswb_tready = fire && (unit == UNIT_SYS);

    // Traps and non-CSR system commands both leave via the CSR unit's event path.
    sys_evt     = exc || ((unit == UNIT_SYS) && (head.sys_cmd != SYS_CSR));
    bru_taken   = !exc && (unit == UNIT_BRU) && s_bruwb_tdata.taken;
    raise_flush = sys_evt || bru_taken;
    rf_wr       = !exc && (head.rd != 5'd0);
    csr_wr      = !exc && (unit == UNIT_SYS) && s_syswb_tdata.csr_update;

    wdata = head.immediate;
    case (unit)
      UNIT_ALU: wdata = s_aluwb_tdata.result;
      UNIT_BRU: wdata = s_bruwb_tdata.result;
      UNIT_SYS: wdata = csr_rdata;
      default:  wdata = head.immediate;
    endcase

    next_pc = bru_taken ? s_bruwb_tdata.new_pc : (head.pc + XLEN'(4));

    state_d = ST_RUN;
    if ((state_q == ST_RUN) && fire && raise_flush) begin
      state_d = ST_FLUSH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wbrf_tvalid <= 1'b0;
      m_wbrf_tdata  <= '0;
      csr_we        <= 1'b0;
      csr_waddr     <= '0;
      csr_wdata     <= '0;
      csr_wmask     <= '0;
      flush         <= 1'b0;
      redirect_pc   <= RESET_PC;
      sys_event_vld <= 1'b0;
      sys_event_cmd <= SYS_CSR;
      sys_event_exc <= 1'b0;
      instret       <= '0;
    end else begin
      m_wbrf_tvalid <= fire && rf_wr;
      csr_we        <= fire && csr_wr;
      flush         <= fire && raise_flush;
      sys_event_vld <= fire && sys_evt;
      sys_event_exc <= fire && exc;
      if (fire) begin
        m_wbrf_tdata.wdata   <= wdata;
        m_wbrf_tdata.ex_data <= s_exwb_tdata;
      end
      if (fire && csr_wr) begin
        csr_waddr <= head.csr_addr;
        csr_wdata <= s_syswb_tdata.csr_wdata;
        csr_wmask <= s_syswb_tdata.csr_wmask;
      end
      if (fire && raise_flush) begin
        redirect_pc <= next_pc;
      end
      if (fire && sys_evt) begin
        sys_event_cmd <= head.sys_cmd;
      end
      if (fire && !exc) begin
        instret <= instret + {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
`default_nettype wire
